// File: rtl/alu_pkg.sv
// Shared unit-select codes, sequencer state encoding and default widths for the
// ALU command path.
package alu_pkg;

    localparam int unsigned ALU_WIDTH_DEF = 16;
    localparam int unsigned NUM_UNITS     = 4;

    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_e;

    // One-hot enable vector, bit index equals the unit-select code.
    function automatic logic [NUM_UNITS-1:0] unit_onehot(input logic [1:0] sel);
        unit_onehot = NUM_UNITS'(1) << sel;
    endfunction

endpackage

// File: rtl/alu_result_mux.sv
// Picks the selected unit's flag and result; non-arith results are zero-extended
// to the double-width response bus.
module alu_result_mux
    import alu_pkg::*;
#(
    parameter int unsigned ALU_WIDTH = ALU_WIDTH_DEF
) (
    input  logic [1:0]             sel,
    input  logic [2*ALU_WIDTH-1:0] arith_out,
    input  logic                   arith_flag,
    input  logic [ALU_WIDTH-1:0]   logic_out,
    input  logic                   logic_flag,
    input  logic [ALU_WIDTH-1:0]   cmp_out,
    input  logic                   cmp_flag,
    input  logic [ALU_WIDTH-1:0]   shift_out,
    input  logic                   shift_flag,
    output logic                   flag_c,
    output logic [2*ALU_WIDTH-1:0] data_c
);

    localparam int unsigned RW = 2 * ALU_WIDTH;

    always_comb begin
        flag_c = 1'b0;
        data_c = '0;
        case (sel)
            UNIT_ARITH: begin
                flag_c = arith_flag;
                data_c = arith_out;
            end
            UNIT_LOGIC: begin
                flag_c = logic_flag;
                data_c = RW'(logic_out);
            end
            UNIT_CMP: begin
                flag_c = cmp_flag;
                data_c = RW'(cmp_out);
            end
            UNIT_SHIFT: begin
                flag_c = shift_flag;
                data_c = RW'(shift_out);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Accepts one ALU command at a time, pulses the selected unit's enable, waits for
// that unit's flag (or a timeout) and returns the captured result on a response port.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned ALU_WIDTH = ALU_WIDTH_DEF,
    parameter int unsigned TIMEOUT   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [3:0]             cmd_fun,
    input  logic [ALU_WIDTH-1:0]   cmd_a,
    input  logic [ALU_WIDTH-1:0]   cmd_b,
    output logic [ALU_WIDTH-1:0]   A,
    output logic [ALU_WIDTH-1:0]   B,
    output logic [1:0]             alu_fun,
    output logic                   arith_enable,
    output logic                   logic_enable,
    output logic                   cmp_enable,
    output logic                   shift_enable,
    input  logic [2*ALU_WIDTH-1:0] arith_out,
    input  logic                   arith_flag,
    input  logic [ALU_WIDTH-1:0]   logic_out,
    input  logic                   logic_flag,
    input  logic [ALU_WIDTH-1:0]   cmp_out,
    input  logic                   cmp_flag,
    input  logic [ALU_WIDTH-1:0]   shift_out,
    input  logic                   shift_flag,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [2*ALU_WIDTH-1:0] res_data,
    output logic [1:0]             res_unit,
    output logic                   res_err
);

    localparam int unsigned RW       = 2 * ALU_WIDTH;
    localparam int unsigned CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic [1:0]             sel_q, sel_d;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
    logic [NUM_UNITS-1:0]   en_q, en_d;
    logic                   cmd_ready_d;
    logic [ALU_WIDTH-1:0]   a_d, b_d;
    logic [1:0]             alu_fun_d;
    logic                   res_valid_d, res_err_d;
    logic [RW-1:0]          res_data_d;
    logic [1:0]             res_unit_d;
    logic                   accept, hit_limit;
    logic                   sel_flag_c;
    logic [RW-1:0]          sel_data_c;

    alu_result_mux #(.ALU_WIDTH(ALU_WIDTH)) u_result_mux (
        .sel        (sel_q),
        .arith_out  (arith_out),
        .arith_flag (arith_flag),
        .logic_out  (logic_out),
        .logic_flag (logic_flag),
        .cmp_out    (cmp_out),
        .cmp_flag   (cmp_flag),
        .shift_out  (shift_out),
        .shift_flag (shift_flag),
        .flag_c     (sel_flag_c),
        .data_c     (sel_data_c)
    );

    assign accept    = cmd_valid && cmd_ready;
    // Saturating increment; the limit is reached one WAIT cycle before TIMEOUT elapses.
    assign cnt_inc   = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CW'(1);
    assign hit_limit = (cnt_inc == CNT_LAST);

    assign arith_enable = en_q[UNIT_ARITH];
    assign logic_enable = en_q[UNIT_LOGIC];
    assign cmp_enable   = en_q[UNIT_CMP];
    assign shift_enable = en_q[UNIT_SHIFT];

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (sel_flag_c || hit_limit) state_d = RESP;
            RESP:    if (res_valid && res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for every registered output; a flag in the limit cycle wins.
    always_comb begin
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        en_d        = '0;
        a_d         = A;
        b_d         = B;
        alu_fun_d   = alu_fun;
        res_valid_d = res_valid;
        res_data_d  = res_data;
        res_unit_d  = res_unit;
        res_err_d   = res_err;
        cmd_ready_d = (state_d == IDLE);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d       = cmd_a;
                    b_d       = cmd_b;
                    alu_fun_d = cmd_fun[1:0];
                    sel_d     = cmd_fun[3:2];
                    en_d      = unit_onehot(cmd_fun[3:2]);
                end
            end
            ISSUE: cnt_d = '0;
            WAIT: begin
                if (sel_flag_c) begin
                    res_valid_d = 1'b1;
                    res_data_d  = sel_data_c;
                    res_unit_d  = sel_q;
                    res_err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                    if (hit_limit) begin
                        res_valid_d = 1'b1;
                        res_data_d  = '0;
                        res_unit_d  = sel_q;
                        res_err_d   = 1'b1;
                    end
                end
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    res_err_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sel_q     <= '0;
            cnt_q     <= '0;
            en_q      <= '0;
            cmd_ready <= 1'b0;
            A         <= '0;
            B         <= '0;
            alu_fun   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_unit  <= '0;
            res_err   <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            cmd_ready <= cmd_ready_d;
            A         <= a_d;
            B         <= b_d;
            alu_fun   <= alu_fun_d;
            res_valid <= res_valid_d;
            res_data  <= res_data_d;
            res_unit  <= res_unit_d;
            res_err   <= res_err_d;
        end
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Initiator side of the ALU unit-enable/flag interface. It accepts one command at a time over a valid/ready port and decodes the 4-bit function into a unit select plus a 2-bit unit-local function. It pulses the selected unit's enable for one cycle, then waits for that unit's registered flag and captures its result. The result is presented on a valid/ready response port; a timeout guards against a unit that never responds.

Parameters:
ALU_WIDTH, 16, operand and unit-result width
TIMEOUT, 8, WAIT cycles without the selected flag before an error response (must be ≥ 2)

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-low
cmd_valid  input  1  command offered
cmd_ready  output  1  sequencer can accept a command
cmd_fun  input  4  [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift); [1:0] unit-local function
cmd_a  input  ALU_WIDTH  operand A
cmd_b  input  ALU_WIDTH  operand B
A  output  ALU_WIDTH  operand A to units
B  output  ALU_WIDTH  operand B to units
alu_fun  output  2  unit-local function to units
arith_enable, logic_enable, cmp_enable, shift_enable  output  1 each  unit enables
arith_out  input  2*ALU_WIDTH  arithmetic result
arith_flag  input  1  arithmetic result valid
logic_out, cmp_out, shift_out  input  ALU_WIDTH each  unit results
logic_flag, cmp_flag, shift_flag  input  1 each  unit result valid
res_valid  output  1  response available
res_ready  input  1  consumer accepts response
res_data  output  2*ALU_WIDTH  captured result; non-arith results zero-extended
res_unit  output  2  unit that produced res_data (copy of cmd_fun[3:2])
res_err  output  1  response is a timeout

Behaviour:
- Reset is synchronous, active-low. While rst=0 at a clk edge:
  - state=IDLE, cmd_ready=0 during reset cycle;
  - A, B, alu_fun, all enables, res_valid, res_data, res_unit, res_err, timeout counter all =0.
- First edge after release: cmd_ready=1.
- All outputs are registered.
- States and transitions:
  - IDLE: cmd_ready=1.
    - On cmd_valid&&cmd_ready, latch cmd_a→A, cmd_b→B, cmd_fun[1:0]→alu_fun, cmd_fun[3:2]→sel.
    - Assert the one enable matching sel on the next cycle; go ISSUE.
  - ISSUE: exactly one enable high for exactly one cycle; cmd_ready=0. Counter cleared. Go WAIT.
  - WAIT: all enables low.
    - Each cycle, inspect only the flag of sel.
    - If high: capture the matching *_out into res_data (zero-extend), res_unit=sel, res_err=0, res_valid=1; go RESP.
    - Else increment counter.
    - If counter reaches TIMEOUT-1 without the flag: res_data=0, res_unit=sel, res_err=1, res_valid=1; go RESP.
  - RESP: res_valid, res_data, res_unit, res_err held stable until res_ready=1.
    - On res_valid&&res_ready: res_valid=0, res_err=0; go IDLE. cmd_ready is high the following cycle.
- Latency: a unit whose flag is registered one cycle after enable is captured in the first WAIT cycle. cmd accept→res_valid = 3 cycles.
- Throughput: one command in flight. Minimum spacing between accepts is 4 cycles with res_ready tied high.
- Flags from non-selected units are ignored in every state. Any flag seen in IDLE, ISSUE or RESP is ignored.
- The flag arriving in the same WAIT cycle as the timeout limit counts as success; the flag has priority.
- A, B and alu_fun hold their last values after the command completes and change only on the next accept.
- cmd_valid while cmd_ready=0 has no effect. The upstream must hold the command; nothing is lost or queued.
- Reset asserted mid-operation (ISSUE/WAIT/RESP) aborts the command with no response. Enables drop on that edge.
- Counter width: clog2(TIMEOUT)+1; it saturates and does not wrap.

Decomposition:
- Shared package (alu_pkg):
  - unit-select constants UNIT_ARITH=2'b00, UNIT_LOGIC=2'b01, UNIT_CMP=2'b10, UNIT_SHIFT=2'b11;
  - state encoding IDLE/ISSUE/WAIT/RESP;
  - default ALU_WIDTH.
- One sub-module is natural: alu_result_mux. It is combinational; it selects flag and zero-extended result by sel. The FSM, counter and registers stay in the top.

Test Plan:
- Logic command: cmd_fun=4'b0101, A=16'h00F0, B=16'h0F00. Bench unit returns logic_out=16'h0001 with logic_flag one cycle after enable.
  - logic_enable high for exactly 1 cycle with alu_fun=2'b01.
  - res_valid 3 cycles after accept, res_data=32'h0000_0001, res_unit=2'b01, res_err=0.
- Arith command: cmd_fun=4'b0010, A=16'h0100, B=16'h0100. Bench returns arith_out=32'h0001_0000.
  - res_data=32'h0001_0000, res_unit=2'b00.
- Timeout: cmd_fun=4'b1100, shift unit never flags, TIMEOUT=8.
  - res_valid with res_err=1, res_data=0, res_unit=2'b11, exactly TIMEOUT cycles after the ISSUE cycle.
- Spurious flags: during WAIT for a cmp command, pulse logic_flag and arith_flag.
  - Ignored; response taken only on cmp_flag, with cmp_out=16'h0003 giving res_data=32'h0000_0003.
- Backpressure: res_ready held low 5 cycles, cmd_valid held high with a second command.
  - res_* stable for all 5 cycles, cmd_ready=0 throughout.
  - Second command accepted the cycle after the handshake; no enable pulses in between.
- Reset mid-WAIT: rst=0 for 1 cycle.
  - Next edge: all outputs 0, no response issued.
  - cmd_ready=1 one cycle after release.
